uart_periph: RTL and testbench



---
 rtl/uart_periph.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_periph.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_periph.sv
// uart_periph: memory-mapped 8N1 UART on the MEM-stage data bus.
// TXD at BASE_ADDR, RXD at +4, CON at +8; level irq; option UART_TX_FIFO_EN.
// Ports: clk, reset (async, high); addr/wr_en/rd_en/wr_data bus in;
//   rd_data comb read data; uart_rx serial in; uart_tx serial out; irq.
module uart_periph #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h40000018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic sel_txd, sel_rxd, sel_con;
  logic txd_wr, con_wr, rxd_rd, con_rd;

  assign sel_txd = addr == BASE_ADDR;
  assign sel_rxd = addr == BASE_ADDR + 32'd4;
  assign sel_con = addr == BASE_ADDR + 32'd8;
  assign txd_wr = wr_en & sel_txd;
  assign con_wr = wr_en & sel_con;
  assign rxd_rd = rd_en & sel_rxd;
  assign con_rd = rd_en & sel_con;

  logic unused_wr_hi;
  assign unused_wr_hi = ^wr_data[31:8];

  logic tx_ie, rx_ie, tx_done, rx_valid;
  logic frame_err, overrun, fifo_full;
  logic [7:0] rx_data;

  // ---------------- TX ----------------
  state_t tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0] tx_bit, tx_bit_next;
  logic [7:0] tx_shift, tx_byte;
  logic tx_tick, tx_avail, tx_window, tx_load;
  logic tx_d, tx_busy, tx_done_set;

  assign tx_tick = tx_cnt == CNT_MAX;
  assign tx_load = tx_avail & tx_window;

`ifdef UART_TX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] fifo_wp, fifo_rp;
  logic [2:0] fifo_cnt;
  logic fifo_push;

  assign fifo_push = txd_wr & (fifo_cnt != 3'd4);
  assign fifo_full = fifo_cnt == 3'd4;
  assign tx_avail = fifo_cnt != 3'd0;
  assign tx_byte = fifo_mem[fifo_rp];
  // Reloading straight out of STOP keeps queued frames gap-free.
  assign tx_window = (tx_state == S_IDLE) |
                     ((tx_state == S_STOP) & tx_tick);

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[fifo_wp] <= wr_data[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_wp  <= '0;
      fifo_rp  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) fifo_wp <= fifo_wp + 2'd1;
      if (tx_load) fifo_rp <= fifo_rp + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b0, fifo_push} - {2'b0, tx_load};
    end
  end
`else
  assign fifo_full = 1'b0;
  assign tx_avail = txd_wr;
  assign tx_byte = wr_data[7:0];
  assign tx_window = tx_state == S_IDLE;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= (tx_state == S_IDLE || tx_tick) ? '0 : tx_cnt + CNT_ONE;
      tx_bit   <= tx_bit_next;
      if (tx_load) tx_shift <= tx_byte;
      uart_tx  <= tx_d;
    end
  end

  always_comb begin
    tx_next = tx_state;
    tx_bit_next = tx_bit;
    unique case (tx_state)
      S_IDLE:  if (tx_load) tx_next = S_START;
      S_START: if (tx_tick) begin
        tx_next = S_DATA;
        tx_bit_next = '0;
      end
      S_DATA:  if (tx_tick) begin
        tx_bit_next = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_next = S_STOP;
      end
      S_STOP:  if (tx_tick) tx_next = tx_load ? S_START : S_IDLE;
      default: tx_next = S_IDLE;
    endcase
  end

  // Line level is registered from the state being entered.
  always_comb begin
    tx_d = 1'b1;
    unique case (tx_next)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_shift[tx_bit_next];
      default: tx_d = 1'b1;
    endcase
    tx_busy = tx_state != S_IDLE;
    tx_done_set = (tx_state == S_STOP) & tx_tick & (tx_next != S_START);
  end

  // ---------------- RX ----------------
  state_t rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0] rx_bit, rx_bit_next;
  logic [7:0] rx_shift;
  logic rx_s1, rx_s2, rx_prev;
  logic rx_tick, rx_fall, rx_ok, rx_ferr;

  assign rx_tick = rx_cnt == CNT_MAX;
  assign rx_fall = rx_prev & ~rx_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_next;
      rx_cnt   <= (rx_state == S_IDLE || rx_next != rx_state || rx_tick)
                  ? '0 : rx_cnt + CNT_ONE;
      rx_bit   <= rx_bit_next;
      if (rx_state == S_DATA && rx_tick)
        rx_shift <= {rx_s2, rx_shift[7:1]};
    end
  end

  always_comb begin
    rx_next = rx_state;
    rx_bit_next = rx_bit;
    unique case (rx_state)
      S_IDLE:  if (rx_fall) rx_next = S_START;
      S_START: if (rx_cnt == CNT_HALF) begin
        rx_next = rx_s2 ? S_IDLE : S_DATA;
        rx_bit_next = '0;
      end
      S_DATA:  if (rx_tick) begin
        rx_bit_next = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_next = S_STOP;
      end
      S_STOP:  if (rx_tick) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ok   = (rx_state == S_STOP) & rx_tick & rx_s2;
    rx_ferr = (rx_state == S_STOP) & rx_tick & ~rx_s2;
  end

  // ---------------- flags ----------------
  // Setting events win over read-to-clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ie     <= 1'b0;
      rx_ie     <= 1'b0;
      tx_done   <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_data   <= '0;
      irq       <= 1'b0;
    end else begin
      if (con_wr) begin
        tx_ie <= wr_data[0];
        rx_ie <= wr_data[1];
      end
      if (tx_done_set) tx_done <= 1'b1;
      else if (con_rd) tx_done <= 1'b0;
      if (rx_ok) rx_valid <= 1'b1;
      else if (rxd_rd) rx_valid <= 1'b0;
      if (rx_ok) rx_data <= rx_shift;
      if (rx_ferr) frame_err <= 1'b1;
      else if (con_rd) frame_err <= 1'b0;
      if (rx_ok & rx_valid) overrun <= 1'b1;
      else if (con_rd) overrun <= 1'b0;
      irq <= (tx_ie & tx_done) | (rx_ie & rx_valid);
    end
  end

  logic [7:0] con_val;
  assign con_val = {fifo_full, overrun, frame_err, tx_busy,
                    rx_valid, tx_done, rx_ie, tx_ie};

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      unique case (1'b1)
        sel_rxd: rd_data = {24'b0, rx_data};
        sel_con: rd_data = {24'b0, con_val};
        default: rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// tb_uart_periph: directed bench for uart_periph at CLKS_PER_BIT=4.
// Covers reset, TX framing, busy drop, RX, frame error, overrun, glitch.
module tb_uart_periph;

  localparam logic [31:0] TXD = 32'h40000018;
  localparam logic [31:0] RXD = 32'h4000001C;
  localparam logic [31:0] CON = 32'h40000020;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        uart_rx;
  logic        uart_tx;
  logic        irq;

  int vectors = 0;
  int errors = 0;

  uart_periph #(
    .CLKS_PER_BIT(4),
    .BASE_ADDR(32'h40000018)
  ) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wr_data = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    addr = '0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input string tag,
                        input logic [31:0] exp);
    addr = a;
    rd_en = 1'b1;
    #1;
    chk(tag, rd_data, exp);
    tick();
    rd_en = 1'b0;
    addr = '0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (4) tick();
    end
    uart_rx = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] fr;
    logic [9:0] cap;
    int zeros;

    reset = 1'b1;
    addr = '0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = '0;
    uart_rx = 1'b1;
    repeat (2) tick();
    chk("rst_tx", uart_tx, 1);
    chk("rst_irq", irq, 0);
    bus_rd(CON, "rst_con", 0);
    reset = 1'b0;
    tick();

    // TX frame 0x41 with tx_ie
    bus_wr(CON, 32'h1);
    bus_wr(TXD, 32'h41);
    fr = {1'b1, 8'h41, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        chk("tx_bit", uart_tx, fr[b]);
        if (c == 1) begin
          addr = CON;
          rd_en = 1'b1;
          #1;
          chk("tx_busy", rd_data[4], 1);
          tick();
          rd_en = 1'b0;
          addr = '0;
        end else begin
          tick();
        end
      end
    end
    tick();
    chk("tx_irq_set", irq, 1);
    chk("tx_idle", uart_tx, 1);
    bus_rd(CON, "tx_con_done", 32'h05);
    bus_rd(CON, "tx_con_clr", 32'h01);
    chk("tx_irq_clr", irq, 0);

    // busy drop: 0x55 then 0xAA two cycles later
    bus_wr(TXD, 32'h55);
    tick();
    bus_wr(TXD, 32'hAA);
    for (int b = 0; b < 10; b++) begin
      cap[b] = uart_tx;
      repeat (4) tick();
    end
    chk("drop_frame", {22'b0, cap}, {22'b0, 1'b1, 8'h55, 1'b0});
    zeros = 0;
    repeat (48) begin
      if (!uart_tx) zeros++;
      tick();
    end
    chk("drop_idle", zeros, 0);
    bus_rd(CON, "drop_con", 32'h05);
    bus_wr(CON, 32'h2);
    tick();
    chk("rx_irq_idle", irq, 0);

    // RX byte 0xC3
    send_rx(8'hC3, 1'b1);
    repeat (4) tick();
    chk("rx_irq_set", irq, 1);
    bus_rd(CON, "rx_con_valid", 32'h0A);
    bus_rd(RXD, "rx_data", 32'hC3);
    bus_rd(CON, "rx_con_clr", 32'h02);
    chk("rx_irq_clr", irq, 0);

    // frame error: 0x12 with low stop bit
    send_rx(8'h12, 1'b0);
    repeat (4) tick();
    bus_rd(CON, "ferr_con", 32'h22);
    bus_rd(CON, "ferr_clr", 32'h02);

    // overrun: two frames without reading RXD
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (4) tick();
    bus_rd(CON, "ovr_con", 32'h4A);
    bus_rd(RXD, "ovr_data", 32'h22);
    bus_rd(CON, "ovr_clr", 32'h02);

    // one-cycle glitch, then a real frame must still be received
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    repeat (10) tick();
    bus_rd(CON, "glitch_con", 32'h02);
    send_rx(8'h5A, 1'b1);
    repeat (4) tick();
    bus_rd(RXD, "glitch_after", 32'h5A);
    bus_rd(CON, "glitch_clr", 32'h02);

    // unmapped address reads 0
    bus_rd(BASE_ADDR_OFF(12), "unmapped", 0);

    // reset mid-transmission during DATA
    bus_wr(TXD, 32'h00);
    repeat (8) tick();
    chk("mid_data", uart_tx, 0);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_tx", uart_tx, 1);
    chk("mid_rst_irq", irq, 0);
    bus_rd(CON, "mid_rst_con", 0);
    reset = 1'b0;
    tick();
    bus_rd(CON, "post_rst_con", 0);
    zeros = 0;
    repeat (40) begin
      if (!uart_tx) zeros++;
      tick();
    end
    chk("post_rst_idle", zeros, 0);
    chk("post_rst_irq", irq, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  function automatic logic [31:0] BASE_ADDR_OFF(input int off);
    return TXD + 32'(off);
  endfunction

endmodule
